ob_arbiter: RTL and testbench

OB_ARBITER -- requirements
Module: ob_arbiter

---
 rtl/ob_arbiter.sv | 148 ++++++++++++++
 tb/tb_ob_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ob_arbiter.sv
// ob_arbiter -- two-requester packet arbiter driving a registered byte bus.
//
// Each packet on ob is: header {4'hA,3'b000,owner}, then the owner's bytes up
// to and including the one marked last. Valid bytes carry odd parity
// (ob_pty = ~^ob_data). The idle pattern 0x00 / pty 0 has deliberately bad
// parity, so a receiver can tell gaps from data.
//
// Optional feature (define OB_ARBITER_TIMEOUT_EN): stall timeout. After
// TIMEOUT_CYCLES consecutive gap cycles in DATA the packet is aborted with
// byte 0xEE and a one-cycle abort pulse. Without it, DATA waits indefinitely.
//
// Ports:
//   ext_clk      sole clock, rising edge
//   ext_rst_n    synchronous active-low reset
//   reqN_valid/reqN_data/reqN_last  requester N byte stream (N = 0,1)
//   reqN_ready   high only in DATA for the current owner
//   ob_data      registered output byte
//   ob_pty       registered parity of ob_data
//   busy         state is not IDLE
//   owner        current / last granted requester (also the round-robin pointer)
//   abort        one-cycle pulse on timeout abort (tied 0 without the feature)
module ob_arbiter #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic       ext_clk,
   input  logic       ext_rst_n,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   input  logic       req0_last,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   input  logic       req1_last,
   output logic       req1_ready,
   output logic [7:0] ob_data,
   output logic       ob_pty,
   output logic       busy,
   output logic       owner,
   output logic       abort
);

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("ob_arbiter: TIMEOUT_CYCLES must be in 2..255");
   end

   typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

   localparam logic [7:0] IDLE_BYTE  = 8'h00;
   localparam logic [7:0] ABORT_BYTE = 8'hEE;

   state_t     state;
   logic       own_valid, own_last, own_ready, own_hs;
   logic [7:0] own_data;
   logic [7:0] hdr_byte;

   // Owner-selected view of the requester inputs; the non-owner is ignored.
   assign own_valid = owner ? req1_valid : req0_valid;
   assign own_last  = owner ? req1_last  : req0_last;
   assign own_data  = owner ? req1_data  : req0_data;
   assign own_ready = owner ? req1_ready : req0_ready;
   assign own_hs    = own_valid & own_ready;
   assign hdr_byte  = {4'hA, 3'b000, owner};
   assign busy      = (state != IDLE);

`ifdef OB_ARBITER_TIMEOUT_EN
   localparam logic [7:0] STALL_MAX = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] stall_cnt;
`else
   assign abort = 1'b0;
`endif

   always_ff @(posedge ext_clk) begin
      if (!ext_rst_n) begin
         state      <= IDLE;
         ob_data    <= IDLE_BYTE;
         ob_pty     <= 1'b0;
         req0_ready <= 1'b0;
         req1_ready <= 1'b0;
         owner      <= 1'b1;   // req0 wins the first tie
`ifdef OB_ARBITER_TIMEOUT_EN
         abort      <= 1'b0;
         stall_cnt  <= 8'd0;
`endif
      end else begin
`ifdef OB_ARBITER_TIMEOUT_EN
         abort <= 1'b0;
`endif
         case (state)
            IDLE: begin
               // Always at least one idle byte here, which separates packets.
               ob_data <= IDLE_BYTE;
               ob_pty  <= 1'b0;
               if (req0_valid | req1_valid) begin
                  if (req0_valid & req1_valid) owner <= ~owner;
                  else                         owner <= req1_valid;
                  state <= HDR;
               end
            end
            HDR: begin
               ob_data    <= hdr_byte;
               ob_pty     <= ~^hdr_byte;
               req0_ready <= ~owner;
               req1_ready <= owner;
               state      <= DATA;
`ifdef OB_ARBITER_TIMEOUT_EN
               stall_cnt  <= 8'd0;
`endif
            end
            DATA: begin
               if (own_hs) begin
                  ob_data <= own_data;
                  ob_pty  <= ~^own_data;
`ifdef OB_ARBITER_TIMEOUT_EN
                  stall_cnt <= 8'd0;
`endif
                  if (own_last) begin
                     req0_ready <= 1'b0;
                     req1_ready <= 1'b0;
                     state      <= IDLE;
                  end
               end else begin
`ifdef OB_ARBITER_TIMEOUT_EN
                  // This gap would be the TIMEOUT_CYCLES-th in a row: abort.
                  if (stall_cnt == STALL_MAX) begin
                     ob_data    <= ABORT_BYTE;
                     ob_pty     <= ~^ABORT_BYTE;
                     abort      <= 1'b1;
                     req0_ready <= 1'b0;
                     req1_ready <= 1'b0;
                     stall_cnt  <= 8'd0;
                     state      <= IDLE;
                  end else begin
                     ob_data   <= IDLE_BYTE;
                     ob_pty    <= 1'b0;
                     stall_cnt <= stall_cnt + 8'd1;
                  end
`else
                  ob_data <= IDLE_BYTE;
                  ob_pty  <= 1'b0;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ob_arbiter.sv
// Table-driven bench for ob_arbiter. Each record holds one cycle of inputs and
// the outputs expected after that rising edge; expectations are queued when
// the stimulus is driven and popped when the DUT output is sampled.
module tb_ob_arbiter;

   logic       ext_clk = 1'b0;
   logic       ext_rst_n;
   logic       req0_valid, req0_last, req0_ready;
   logic [7:0] req0_data;
   logic       req1_valid, req1_last, req1_ready;
   logic [7:0] req1_data;
   logic [7:0] ob_data;
   logic       ob_pty, busy, owner, abort;

   ob_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .ext_clk(ext_clk), .ext_rst_n(ext_rst_n),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
      .ob_data(ob_data), .ob_pty(ob_pty), .busy(busy), .owner(owner), .abort(abort)
   );

   always #5 ext_clk = ~ext_clk;

   typedef struct {
      logic       rst;
      logic       v0, l0;
      logic [7:0] d0;
      logic       v1, l1;
      logic [7:0] d1;
      logic [7:0] ob;
      logic       pty, r0, r1, bz, ab, ow;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Expected parity: idle 0x00 carries bad parity 0; every real byte is odd.
   task automatic add(input logic rst,
                      input logic v0, input logic [7:0] d0, input logic l0,
                      input logic v1, input logic [7:0] d1, input logic l1,
                      input logic [7:0] ob, input logic r0, input logic r1,
                      input logic bz, input logic ab, input logic ow);
      vec_t v;
      v.rst = rst; v.v0 = v0; v.d0 = d0; v.l0 = l0; v.v1 = v1; v.d1 = d1; v.l1 = l1;
      v.ob = ob; v.pty = (ob == 8'h00) ? 1'b0 : ~^ob;
      v.r0 = r0; v.r1 = r1; v.bz = bz; v.ab = ab; v.ow = ow;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input int step, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s step %0d: got %h want %h", name, step, act, exp);
      end
   endtask

   initial begin
      vec_t e;
      // reset state
      add(0, 0,8'h00,0, 0,8'h00,0, 8'h00, 0,0,0,0,1);
      add(0, 0,8'h00,0, 0,8'h00,0, 8'h00, 0,0,0,0,1);
      // req0 alone: 0x11, 0x22(last)
      add(1, 1,8'h11,0, 0,8'h00,0, 8'h00, 0,0,1,0,0);
      add(1, 1,8'h11,0, 0,8'h00,0, 8'hA0, 1,0,1,0,0);
      add(1, 1,8'h11,0, 0,8'h00,0, 8'h11, 1,0,1,0,0);
      add(1, 1,8'h22,1, 0,8'h00,0, 8'h22, 0,0,0,0,0);
      add(1, 0,8'h00,0, 0,8'h00,0, 8'h00, 0,0,0,0,0);
      // reset, then tie: req0 first, idle gap, req1 (round robin), then req0
      add(0, 0,8'h00,0, 0,8'h00,0, 8'h00, 0,0,0,0,1);
      add(1, 1,8'h31,0, 1,8'h41,0, 8'h00, 0,0,1,0,0);
      add(1, 1,8'h31,0, 1,8'h41,0, 8'hA0, 1,0,1,0,0);
      add(1, 1,8'h31,1, 1,8'h41,0, 8'h31, 0,0,0,0,0);
      add(1, 1,8'h33,1, 1,8'h41,0, 8'h00, 0,0,1,0,1);
      add(1, 1,8'h33,1, 1,8'h41,0, 8'hA1, 0,1,1,0,1);
      add(1, 1,8'h33,1, 1,8'h41,0, 8'h41, 0,1,1,0,1);
      add(1, 1,8'h33,1, 1,8'h42,1, 8'h42, 0,0,0,0,1);
      add(1, 1,8'h33,1, 0,8'h00,0, 8'h00, 0,0,1,0,0);
      add(1, 1,8'h33,1, 0,8'h00,0, 8'hA0, 1,0,1,0,0);
      add(1, 1,8'h33,1, 0,8'h00,0, 8'h33, 0,0,0,0,0);
      add(1, 0,8'h00,0, 0,8'h00,0, 8'h00, 0,0,0,0,0);
      // req1 stalls 3 cycles mid-packet
      add(1, 0,8'h00,0, 1,8'h51,0, 8'h00, 0,0,1,0,1);
      add(1, 0,8'h00,0, 1,8'h51,0, 8'hA1, 0,1,1,0,1);
      add(1, 0,8'h00,0, 1,8'h51,0, 8'h51, 0,1,1,0,1);
      for (int i = 0; i < 3; i++) add(1, 0,8'h00,0, 0,8'h00,0, 8'h00, 0,1,1,0,1);
      add(1, 0,8'h00,0, 1,8'h52,1, 8'h52, 0,0,0,0,1);
      add(1, 0,8'h00,0, 0,8'h00,0, 8'h00, 0,0,0,0,1);
      // owner req0 stalls while req1 waits
      add(1, 1,8'h61,0, 1,8'h71,0, 8'h00, 0,0,1,0,0);
      add(1, 1,8'h61,0, 1,8'h71,0, 8'hA0, 1,0,1,0,0);
      add(1, 1,8'h61,0, 1,8'h71,0, 8'h61, 1,0,1,0,0);
`ifdef OB_ARBITER_TIMEOUT_EN
      for (int i = 0; i < 3; i++) add(1, 0,8'h00,0, 1,8'h71,0, 8'h00, 1,0,1,0,0);
      add(1, 0,8'h00,0, 1,8'h71,0, 8'hEE, 0,0,0,1,0);
`else
      for (int i = 0; i < 6; i++) add(1, 0,8'h00,0, 1,8'h71,0, 8'h00, 1,0,1,0,0);
      add(1, 1,8'h62,1, 1,8'h71,0, 8'h62, 0,0,0,0,0);
`endif
      add(1, 0,8'h00,0, 1,8'h71,0, 8'h00, 0,0,1,0,1);
      add(1, 0,8'h00,0, 1,8'h71,0, 8'hA1, 0,1,1,0,1);
      add(1, 0,8'h00,0, 1,8'h71,1, 8'h71, 0,0,0,0,1);
      add(1, 0,8'h00,0, 0,8'h00,0, 8'h00, 0,0,0,0,1);
      // reset during DATA of a req0 packet; following tie goes to req0
      add(1, 1,8'h81,0, 0,8'h00,0, 8'h00, 0,0,1,0,0);
      add(1, 1,8'h81,0, 0,8'h00,0, 8'hA0, 1,0,1,0,0);
      add(1, 1,8'h81,0, 0,8'h00,0, 8'h81, 1,0,1,0,0);
      add(0, 1,8'h81,0, 0,8'h00,0, 8'h00, 0,0,0,0,1);
      add(1, 1,8'h91,1, 1,8'hA5,0, 8'h00, 0,0,1,0,0);
      add(1, 1,8'h91,1, 1,8'hA5,0, 8'hA0, 1,0,1,0,0);
      add(1, 1,8'h91,1, 1,8'hA5,0, 8'h91, 0,0,0,0,0);
      add(1, 0,8'h00,0, 0,8'h00,0, 8'h00, 0,0,0,0,0);

      ext_rst_n = 1'b0;
      req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
      req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
      @(posedge ext_clk); #1;

      for (int i = 0; i < tbl.size(); i++) begin
         ext_rst_n  = tbl[i].rst;
         req0_valid = tbl[i].v0; req0_data = tbl[i].d0; req0_last = tbl[i].l0;
         req1_valid = tbl[i].v1; req1_data = tbl[i].d1; req1_last = tbl[i].l1;
         sb.push_back(tbl[i]);
         @(posedge ext_clk); #1;
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard step %0d: got empty queue want entry", i);
         end else begin
            e = sb.pop_front();
            chk("ob_data", i, ob_data, e.ob);
            chk("ob_pty", i, {7'd0, ob_pty}, {7'd0, e.pty});
            chk("req0_ready", i, {7'd0, req0_ready}, {7'd0, e.r0});
            chk("req1_ready", i, {7'd0, req1_ready}, {7'd0, e.r1});
            chk("busy", i, {7'd0, busy}, {7'd0, e.bz});
            chk("abort", i, {7'd0, abort}, {7'd0, e.ab});
            chk("owner", i, {7'd0, owner}, {7'd0, e.ow});
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
